// File: rtl/aes_cipher_iter.sv
`timescale 1ns/1ps
// Iterative AES encryptor: one round per clock, with round keys expanded on the fly
// from two (AES-256) or one (AES-128) 128-bit key registers.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[a];
endmodule

module aes_cipher_iter #(
    parameter  int KEY_BITS = 128,
    localparam int R        = (KEY_BITS == 256) ? 14 : 10,
    localparam int RW       = $clog2(R + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plain_text,
    input  logic [KEY_BITS-1:0] cipher_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        cipher_text,
    output logic [RW-1:0]       roundnum
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic         accept, last;
    logic [127:0] st, rk, shr, mixed, rnd_out;
    logic [7:0]   sb [16];
    logic [31:0]  ksw_in, ksw_out;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [RW-1:0] idx);
        case (idx)
            0: return 8'h01;  1: return 8'h02;  2: return 8'h04;  3: return 8'h08;
            4: return 8'h10;  5: return 8'h20;  6: return 8'h40;  7: return 8'h80;
            8: return 8'h1b;  9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // XOR-chain the four words of the previous key block with the transformed word t.
    function automatic logic [127:0] kstep(input logic [127:0] k, input logic [31:0] t);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign last        = (roundnum == RW'(R - 1));
    assign cipher_text = st;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) state_nxt = RUN;
    end

    // SubBytes + ShiftRows: output byte (row r, col c) takes input column (c + r) mod 4.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sb[i]));
        assign shr[127-8*i -: 8] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = shr[127-32*c -: 32];
        assign mixed[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end

    for (genvar k = 0; k < 4; k++) begin : g_ksbox
        aes_sbox u_sbox (.a(ksw_in[31-8*k -: 8]), .y(ksw_out[31-8*k -: 8]));
    end

    assign rnd_out = (last ? shr : mixed) ^ rk;

    if (KEY_BITS == 128) begin : g_k128
        logic [127:0] kr;
        assign ksw_in = {kr[23:0], kr[31:24]};
        assign rk     = kstep(kr, ksw_out ^ {rcon(roundnum), 24'h0});
        always_ff @(posedge clk) begin
            if (!rst_n)              kr <= '0;
            else if (accept)         kr <= cipher_key[KEY_BITS-1 -: 128];
            else if (state == RUN)   kr <= rk;
        end
    end else if (KEY_BITS == 256) begin : g_k256
        // kh[r mod 2] holds round key r; the next round uses the other half while the
        // current half is overwritten with round key r+2.
        logic [127:0] kh [2];
        logic         par;
        logic [127:0] kcur;
        assign par    = roundnum[0];
        assign kcur   = kh[~par];
        assign ksw_in = par ? kcur[31:0] : {kcur[23:0], kcur[31:24]};
        assign rk     = kcur;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                kh[0] <= '0;
                kh[1] <= '0;
            end else if (accept) begin
                kh[0] <= cipher_key[KEY_BITS-1 -: 128];
                kh[1] <= cipher_key[127:0];
            end else if (state == RUN) begin
                kh[par] <= kstep(kh[par], ksw_out ^ (par ? 32'h0 : {rcon(roundnum >> 1), 24'h0}));
            end
        end
    end else begin : g_bad_key
        $error("aes_cipher_iter: KEY_BITS must be 128 or 256");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            st       <= '0;
            roundnum <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                st       <= plain_text ^ cipher_key[KEY_BITS-1 -: 128];
                roundnum <= '0;
            end else if (state == RUN) begin
                st       <= rnd_out;
                roundnum <= roundnum + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_cipher_iter.sv
`timescale 1ns/1ps
// Bench for aes_cipher_iter: AES-128 instance checked every cycle against a software
// AES model with a protocol tracker, plus a directed AES-256 instance.
module tb_aes_cipher_iter;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] P2  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] C2  = 128'hff0b844a0853bf7c6934ab4364148fb9;
    localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic [127:0] plain_text = '0, cipher_key = '0;
    logic         in_ready, out_valid;
    logic [127:0] cipher_text;
    logic [3:0]   roundnum;

    logic         in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [127:0] pt2 = '0;
    logic [255:0] key2 = '0;
    logic         in_ready2, out_valid2;
    logic [127:0] ct2;
    logic [3:0]   rn2;

    int errors = 0, checks = 0;
    bit chk_on = 0;
    int rn_log [64];

    aes_cipher_iter #(.KEY_BITS(128)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plain_text(plain_text), .cipher_key(cipher_key), .out_valid(out_valid),
        .out_ready(out_ready), .cipher_text(cipher_text), .roundnum(roundnum));

    aes_cipher_iter #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .plain_text(pt2), .cipher_key(key2), .out_valid(out_valid2),
        .out_ready(out_ready2), .cipher_text(ct2), .roundnum(rn2));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference AES (GF(2^8) arithmetic, FIPS-197 structure) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a, y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        logic [127:0] res;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 4 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m(s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]);
            for (int c = 0; c < 4; c++) begin
                if (r < nr) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- protocol tracker for the AES-128 instance ----------------
    int           m_ph = 0;   // 0 idle, 1 running, 2 result held
    int           m_rn = 0;
    logic [127:0] m_exp = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph = 0;
            m_rn = 0;
        end else if (in_valid && (m_ph == 0 || (m_ph == 2 && out_ready))) begin
            m_exp = aes_model(plain_text, {cipher_key, 128'h0}, 4);
            m_ph  = 1;
            m_rn  = 0;
        end else if (m_ph == 1) begin
            m_rn++;
            if (m_rn == 10) m_ph = 2;
        end else if (m_ph == 2 && out_ready) begin
            m_ph = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_valid", out_valid, m_ph == 2);
            chk("in_ready", in_ready, m_ph == 0 || (m_ph == 2 && out_ready));
            chk("roundnum", roundnum, m_rn);
            if (m_ph == 2) chk("cipher_text", cipher_text, m_exp);
        end
    end

    // Present one block (after one drain edge), then count edges until out_valid.
    task automatic send128(input logic [127:0] pt, input logic [127:0] key, input bit noise, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1; plain_text = pt; cipher_key = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        rn_log[0] = roundnum;
        do begin
            if (noise && lat < 10) begin
                in_valid   = 1'($urandom_range(0, 1));
                plain_text = {$urandom, $urandom, $urandom, $urandom};
                cipher_key = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            lat++;
            rn_log[lat] = roundnum;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
    endtask

    initial begin
        int lat;
        logic [127:0] held;

        @(posedge clk);
        chk_on = 1;
        @(posedge clk); #1;
        chk("rst_cipher_text", cipher_text, 128'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_roundnum", roundnum, 4'd0);
        rst_n = 1'b1;

        chk("model_aes128_a", aes_model(P1, {K1, 128'h0}, 4), C1);
        chk("model_aes128_b", aes_model(P2, {K2, 128'h0}, 4), C2);
        chk("model_aes256", aes_model(P1, K3, 8), C3);

        send128(P1, K1, 0, lat);
        chk("v1_latency", lat, 10);
        chk("v1_cipher_text", cipher_text, C1);

        send128(P2, K2, 0, lat);
        chk("v2_cipher_text", cipher_text, C2);
        for (int k = 0; k <= 10; k++) chk($sformatf("v2_roundnum_%0d", k), rn_log[k], k);

        // Backpressure, then same-edge handoff to the next block.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send128(P1, K1, 0, lat);
        chk("bp_latency", lat, 10);
        held = cipher_text;
        chk("bp_cipher_text", held, C1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_stable", cipher_text, held);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1; in_valid = 1'b1; plain_text = P2; cipher_key = K2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("handoff_out_valid_drop", out_valid, 1'b0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("handoff_latency", lat, 10);
        chk("handoff_cipher_text", cipher_text, C2);

        // Reset in the middle of a block.
        @(posedge clk); #1;
        in_valid = 1'b1; plain_text = P1; cipher_key = K1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_roundnum_before", roundnum, 4'd5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_cipher_text", cipher_text, 128'h0);
        chk("midrst_roundnum", roundnum, 4'd0);
        send128(P1, K1, 0, lat);
        chk("rerun_latency", lat, 10);
        chk("rerun_cipher_text", cipher_text, C1);

        // Random in_valid/data while running.
        send128(P1, K1, 1, lat);
        chk("noise_latency", lat, 10);
        chk("noise_cipher_text", cipher_text, C1);

        // AES-256 instance.
        @(posedge clk); #1;
        in_valid2 = 1'b1; pt2 = P1; key2 = K3;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("a256_roundnum_start", rn2, 4'd0);
        lat = 0;
        while (!out_valid2 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("a256_latency", lat, 14);
        chk("a256_cipher_text", ct2, C3);
        chk("a256_roundnum_done", rn2, 4'd14);
        @(posedge clk); #1;
        chk("a256_out_valid_drop", out_valid2, 1'b0);
        chk("a256_in_ready_idle", in_ready2, 1'b1);
        chk("a256_roundnum_hold", rn2, 4'd14);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 Parameter: KEY_BITS, 128, key length; only 128 (10 rounds) or 256 (14 rounds) is legal; any other value SHALL fail elaboration.
REQ-002 Derived: R = 10 for KEY_BITS=128, 14 for KEY_BITS=256; RW = $clog2(R+1).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  plain_text/cipher_key valid.
REQ-006 in_ready  out  1  block can accept a new block.
REQ-007 plain_text  in  128  plaintext, byte 0 in bits [127:120].
REQ-008 cipher_key  in  KEY_BITS  cipher key, byte 0 in MSBs.
REQ-009 out_valid  out  1  cipher_text holds a finished result.
REQ-010 out_ready  in  1  consumer accepts cipher_text.
REQ-011 cipher_text  out  128  ciphertext, same byte order as plain_text.
REQ-012 roundnum  out  RW  round just applied to the state (0 = initial AddRoundKey).

Function
REQ-013 States: IDLE, RUN, DONE; encoding is free.
REQ-014 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise.
REQ-015 Accept = in_valid && in_ready; on the accept edge, state <= plain_text ^ round key 0; roundnum <= 0; plain_text and cipher_key are sampled on this edge only; FSM -> RUN.
REQ-016 In RUN, each edge applies one round: roundnum <= roundnum+1; SubBytes, ShiftRows, MixColumns, AddRoundKey(roundnum+1).
REQ-017 The final round (roundnum+1 == R) SHALL omit MixColumns; FSM -> DONE on that edge.
REQ-018 Latency: out_valid SHALL rise exactly R edges after the accept edge (10 for AES-128, 14 for AES-256), with no stalls inside RUN.
REQ-019 Round keys SHALL be generated on the fly, one per round, from internal key registers; a full expanded-key table SHALL NOT be stored.
REQ-020 KEY_BITS=128: each key step applies RotWord, SubWord and Rcon[i] to word 3, with Rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-021 KEY_BITS=256: two 128-bit halves are kept; round key r is the half indexed by r mod 2.
REQ-022 KEY_BITS=256 even step: RotWord, SubWord and Rcon, one Rcon per two rounds.
REQ-023 KEY_BITS=256 odd step: SubWord only, no Rcon.
REQ-024 S-box: combinational 256-entry FIPS-197 table; 16 instances for the state and 4 for the key schedule.
REQ-025 out_valid SHALL be 1 only in DONE; cipher_text SHALL be the state register and be held stable while out_valid=1 and out_ready=0.
REQ-026 In DONE with out_ready=1 and no accept: FSM -> IDLE and out_valid drops on the next edge.
REQ-027 In DONE with out_ready=1 and in_valid=1: the result is consumed and the new block is accepted on the same edge, FSM -> RUN; back-to-back throughput is one block per R+1 cycles.
REQ-028 in_valid asserted during RUN SHALL be ignored and SHALL NOT corrupt the block in progress.
REQ-029 roundnum SHALL be R while in DONE.
REQ-030 roundnum SHALL hold its last value in IDLE.

Reset
REQ-031 While rst_n=0 at a posedge: FSM -> IDLE.
REQ-032 Reset values: out_valid=0, in_ready=1 (from IDLE), cipher_text=0, roundnum=0, key registers and state cleared.
REQ-033 Reset asserted during RUN or DONE SHALL abort the operation with no output produced; the first accept after reset SHALL behave identically to one after power-up.
REQ-034 rst_n SHALL have no effect between clock edges, because reset is synchronous.

Verification
REQ-035 KEY_BITS=128; key 000102030405060708090a0b0c0d0e0f; pt 00112233445566778899aabbccddeeff -> cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after accept.
REQ-036 KEY_BITS=128; key 0f1571c947d9e8590cb7add6af7f6798; pt 0123456789abcdeffedcba9876543210 -> ff0b844a0853bf7c6934ab4364148fb9; roundnum steps 0..10.
REQ-037 KEY_BITS=256; key 000102...1e1f; pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089 after 14 edges.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> cipher_text stable and in_ready=0; then assert out_ready with in_valid=1 -> same-edge handoff, and the second result is correct.
REQ-039 Assert rst_n=0 for one edge at roundnum=5 -> out_valid=0, in_ready=1 on the next cycle; a re-run of REQ-035 passes.
REQ-040 Toggle in_valid with random data during RUN -> result unchanged (REQ-035 vector).
